// File: rtl/abs_pump_arbiter.sv
// ---------------------------------------------------------------------------
// abs_pump_arbiter
// Arbitrates the shared ABS recovery pump between the four wheel channels.
// The pump is spun up before the first grant, each grant lasts at least
// MIN_HOLD cycles, a contended owner is preempted after MAX_HOLD cycles, and
// every hand-over inserts one dead cycle so two release valves never overlap.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high
//   req[3:0]   per-wheel pump request (bit0 FL, bit1 FR, bit2 RL, bit3 RR)
//   grant[3:0] one-hot (or zero) release-valve permission
//   pump_on    recovery pump motor enable
//   active_id  index of current or last owner
//   busy       high whenever the arbiter is not idle
//   preempt    one-cycle pulse during the dead cycle after a forced preemption
//
// Build option: define ABS_PUMP_FRONT_PRIORITY_EN to give the front wheels
// strict priority over the rear wheels (round-robin inside each pair).
//
// State | Meaning
// IDLE   | pump off, no grant
// SPINUP | pump running up to speed, no grant yet
// SERVE  | pump on, grant held by active_id
// SWITCH | single valve dead-time cycle between owners
// ---------------------------------------------------------------------------
module abs_pump_arbiter #(
    parameter int SPINUP_CYC = 2,
    parameter int MIN_HOLD   = 4,
    parameter int MAX_HOLD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       pump_on,
    output logic [1:0] active_id,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {IDLE, SPINUP, SERVE, SWITCH} state_t;

    localparam logic [3:0] SPIN_LAST = 4'(SPINUP_CYC - 1);
    localparam logic [4:0] HOLD_MIN  = 5'(MIN_HOLD - 1);
    localparam logic [4:0] HOLD_MAX  = 5'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [3:0] spin_cnt, spin_nxt;
    logic [4:0] hold_cnt, hold_nxt;
    logic [1:0] id_nxt;
    logic       preempt_nxt;
    logic [3:0] arb_req;
    logic [3:0] owner_mask;
    logic [3:0] rivals;
    logic [1:0] winner;

    // First requesting channel after 'last', wrapping modulo 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign owner_mask = 4'b0001 << active_id;

`ifdef ABS_PUMP_FRONT_PRIORITY_EN
    // Front requests mask out the rear pair; a front owner is only contested
    // by the other front wheel, a rear owner by anyone.
    assign arb_req = (req[1:0] != 2'b00) ? {2'b00, req[1:0]} : req;
    assign rivals  = active_id[1] ? (req & ~owner_mask)
                                  : (req & 4'b0011 & ~owner_mask);
`else
    assign arb_req = req;
    assign rivals  = req & ~owner_mask;
`endif

    assign winner = rr_pick(arb_req, active_id);

    always_comb begin
        state_nxt   = state;
        spin_nxt    = spin_cnt;
        hold_nxt    = hold_cnt;
        id_nxt      = active_id;
        preempt_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = SPINUP;
                    spin_nxt  = 4'd0;
                end
            end
            SPINUP: begin
                if (req == 4'b0000) begin
                    state_nxt = IDLE;
                    spin_nxt  = 4'd0;
                end else if (spin_cnt == SPIN_LAST) begin
                    state_nxt = SERVE;
                    spin_nxt  = 4'd0;
                    hold_nxt  = 5'd0;
                    id_nxt    = winner;
                end else begin
                    spin_nxt = spin_cnt + 4'd1;
                end
            end
            SERVE: begin
                // Release takes precedence so a dropping owner is never
                // reported as preempted.
                if (!req[active_id] && (hold_cnt >= HOLD_MIN)) begin
                    state_nxt = SWITCH;
                    hold_nxt  = 5'd0;
                end else if ((hold_cnt == HOLD_MAX) && (rivals != 4'b0000)) begin
                    state_nxt   = SWITCH;
                    hold_nxt    = 5'd0;
                    preempt_nxt = 1'b1;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_nxt = hold_cnt + 5'd1;
                end
            end
            SWITCH: begin
                if (req != 4'b0000) begin
                    state_nxt = SERVE;
                    hold_nxt  = 5'd0;
                    id_nxt    = winner;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they align with
    // the state they describe and clear asynchronously with reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            spin_cnt  <= 4'd0;
            hold_cnt  <= 5'd0;
            active_id <= 2'd3;
            grant     <= 4'b0000;
            pump_on   <= 1'b0;
            busy      <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            spin_cnt  <= spin_nxt;
            hold_cnt  <= hold_nxt;
            active_id <= id_nxt;
            grant     <= (state_nxt == SERVE) ? (4'b0001 << id_nxt) : 4'b0000;
            pump_on   <= (state_nxt != IDLE);
            busy      <= (state_nxt != IDLE);
            preempt   <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_abs_pump_arbiter.sv
module tb_abs_pump_arbiter;

    localparam int SPINUP_CYC = 2;
    localparam int MIN_HOLD   = 4;
    localparam int MAX_HOLD   = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       pump_on;
    logic [1:0] active_id;
    logic       busy;
    logic       preempt;

    int checks = 0;
    int failures = 0;

    abs_pump_arbiter #(
        .SPINUP_CYC(SPINUP_CYC),
        .MIN_HOLD  (MIN_HOLD),
        .MAX_HOLD  (MAX_HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .pump_on  (pump_on),
        .active_id(active_id),
        .busy     (busy),
        .preempt  (preempt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic       pump_on;
        logic       busy;
        logic       preempt;
        logic [1:0] id;
    } vec_t;

    vec_t vecs[8];

    // Reference model: phase 0 idle, 1 spin-up, 2 serving, 3 dead time.
    int m_phase, m_age, m_owner, m_pre;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        m_phase = 0;
        m_age   = 0;
        m_owner = 3;
        m_pre   = 0;
    endtask

    function automatic bit in_pool(input logic [3:0] r, input int j);
`ifdef ABS_PUMP_FRONT_PRIORITY_EN
        if (r[1:0] != 2'b00) return (j < 2) && r[j];
`endif
        return r[j];
    endfunction

    function automatic int m_pick(input logic [3:0] r);
        for (int k = 1; k <= 4; k++)
            if (in_pool(r, (m_owner + k) % 4)) return (m_owner + k) % 4;
        return m_owner;
    endfunction

    function automatic bit m_contested(input logic [3:0] r);
        for (int j = 0; j < 4; j++) begin
            if (j == m_owner || !r[j]) continue;
`ifdef ABS_PUMP_FRONT_PRIORITY_EN
            if (m_owner < 2 && j >= 2) continue;
`endif
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic [3:0] r);
        m_pre = 0;
        case (m_phase)
            0: if (r != 0) begin m_phase = 1; m_age = 0; end
            1: begin
                if (r == 0) m_phase = 0;
                else if (m_age + 1 >= SPINUP_CYC) begin
                    m_phase = 2; m_owner = m_pick(r); m_age = 0;
                end else m_age++;
            end
            2: begin
                // m_age+1 = cycles of grant served so far, including this one
                if (!r[m_owner] && m_age + 1 >= MIN_HOLD) m_phase = 3;
                else if (m_age + 1 >= MAX_HOLD && m_contested(r)) begin
                    m_phase = 3; m_pre = 1;
                end else m_age++;
            end
            default: begin
                if (r != 0) begin m_phase = 2; m_owner = m_pick(r); m_age = 0; end
                else m_phase = 0;
            end
        endcase
    endtask

    initial begin
        logic [3:0] exp_order[5];
        logic [3:0] exp_g;
        int len, wait_n, thr;

        // Single wheel: spin-up, serve, early drop honoured only after MIN_HOLD.
        vecs[0] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3};
        vecs[1] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd3};
        vecs[2] = '{4'b0001, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[3] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[4] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[5] = '{4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[6] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd0};
        vecs[7] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0};

        reset = 1'b1;
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_pump_on", pump_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_preempt", preempt, 0);
        chk("rst_active_id", active_id, 3);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req;
            tick();
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].grant);
            chk($sformatf("vec%0d_pump_on", i), pump_on, vecs[i].pump_on);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_preempt", i), preempt, vecs[i].preempt);
            chk($sformatf("vec%0d_id", i), active_id, vecs[i].id);
        end

`ifndef ABS_PUMP_FRONT_PRIORITY_EN
        // All four wheels contend: full-length grants in rotation with preemption.
        do_reset();
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        req = 4'b1111;
        wait_n = 0;
        while (grant == 0 && wait_n < 10) begin tick(); wait_n++; end
        chk("rr_first_grant_latency", wait_n, SPINUP_CYC + 1);
        for (int g = 0; g < 5; g++) begin
            exp_g = exp_order[g];
            chk($sformatf("rr_grant%0d", g), grant, exp_g);
            if (g < 4) begin
                len = 0;
                while (grant == exp_g && len < 40) begin len++; tick(); end
                chk($sformatf("rr_len%0d", g), len, MAX_HOLD);
                chk($sformatf("rr_dead%0d_grant", g), grant, 0);
                chk($sformatf("rr_dead%0d_preempt", g), preempt, 1);
                chk($sformatf("rr_dead%0d_pump_on", g), pump_on, 1);
                tick();
            end
        end
`endif

        // Lone requester keeps the pump indefinitely, never preempted.
        do_reset();
        req = 4'b0100;
        for (int i = 0; i < SPINUP_CYC + 1; i++) tick();
        for (int i = 0; i < 100; i++) begin
            chk($sformatf("solo_grant_c%0d", i), grant, 4'b0100);
            chk($sformatf("solo_preempt_c%0d", i), preempt, 0);
            tick();
        end

        // Reset mid-grant clears outputs immediately; next grant needs full spin-up.
        do_reset();
        req = 4'b0010;
        for (int i = 0; i < SPINUP_CYC + 3; i++) tick();
        chk("midrst_pre_grant", grant, 4'b0010);
        #3 reset = 1'b1;
        #1;
        chk("midrst_grant", grant, 0);
        chk("midrst_pump_on", pump_on, 0);
        chk("midrst_id", active_id, 3);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst_spin1_grant", grant, 0);
        chk("midrst_spin1_pump", pump_on, 1);
        tick();
        chk("midrst_spin2_grant", grant, 0);
        tick();
        chk("midrst_regrant", grant, 4'b0010);

`ifdef ABS_PUMP_FRONT_PRIORITY_EN
        do_reset();
        req = 4'b1101;
        for (int i = 0; i < SPINUP_CYC + 1; i++) tick();
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("front_grant_c%0d", i), grant, 4'b0001);
            chk($sformatf("front_preempt_c%0d", i), preempt, 0);
            tick();
        end
        req = 4'b1100;
        wait_n = 0;
        while (grant != 4'b0100 && wait_n < 10) begin tick(); wait_n++; end
        chk("front_then_rl", grant, 4'b0100);
`endif

        // Randomised traffic against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            thr = (c < 2000) ? 40 : 8;
            for (int b = 0; b < 4; b++)
                if ($urandom_range(thr - 1) == 0) req[b] = ~req[b];
            if ($urandom_range(299) == 0) req = 4'b0000;
            if ($urandom_range(499) == 0) req = 4'b1111;
            tick();
            model_step(req);
            chk($sformatf("rand_c%0d_grant", c), grant,
                (m_phase == 2) ? (32'd1 << m_owner) : 32'd0);
            chk($sformatf("rand_c%0d_pump_on", c), pump_on, (m_phase != 0));
            chk($sformatf("rand_c%0d_busy", c), busy, (m_phase != 0));
            chk($sformatf("rand_c%0d_preempt", c), preempt, m_pre);
            chk($sformatf("rand_c%0d_id", c), active_id, m_owner);
            chk($sformatf("rand_c%0d_safe", c),
                ((grant & (grant - 4'd1)) == 0) && (grant == 0 || pump_on), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
